// File: rtl/instr_dcd_pkg.sv
// instr_dcd_pkg: shared state encoding and command-byte layout for instr_dcd_burst
package instr_dcd_pkg;
  typedef enum logic [1:0] {IDLE, WR_DATA, RD_LOAD, RD_SHIFT} state_e;
  localparam int CMD_WR_BIT = 7;
  localparam int CMD_BURST_BIT = 6;
  localparam logic [7:0] RD_FILL_DEF = 8'h00;
endpackage

// File: rtl/instr_addr_ctr.sv
// instr_addr_ctr: register address counter with load, wrapping increment and range flags
module instr_addr_ctr #(
  parameter int ADDR_W = 6,
  parameter int ADDR_LIMIT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              oor,
  output logic              ld_oor,
  output logic              inc_oor
);
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(ADDR_LIMIT);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ADDR_LIMIT - 1);
  logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
  always_comb begin
    addr_inc = (addr_q == LAST) ? '0 : addr_q + 1'b1;
    addr_d = load ? load_addr : inc ? addr_inc : addr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) addr_q <= '0;
    else addr_q <= addr_d;
  // range flags are offered for the candidate addresses so the decoder never loops through addr_d
  assign addr = addr_q;
  assign oor = {1'b0, addr_q} >= LIM;
  assign ld_oor = {1'b0, load_addr} >= LIM;
  assign inc_oor = {1'b0, addr_inc} >= LIM;
endmodule

// File: rtl/instr_dcd_burst.sv
// instr_dcd_burst: SPI command decoder issuing single/burst register reads and writes.
// Define INSTR_DCD_ERR_EN to add the sticky err flag with err/err_clr ports.
module instr_dcd_burst
  import instr_dcd_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int ADDR_LIMIT = 64,
  parameter logic [7:0] RD_FILL = RD_FILL_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              byte_sync,
  input  logic              frame_end,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data_read,
  output logic [7:0]        data_write,
`ifdef INSTR_DCD_ERR_EN
  output logic              err,
  input  logic              err_clr,
`endif
  output logic              busy
);
  state_e state_q, state_d;
  logic burst_q, burst_d, read_q, read_d, write_q, write_d, busy_q, busy_d;
  logic [7:0] data_out_q, data_out_d, data_write_q, data_write_d;
  logic load, inc, oor, ld_oor, inc_oor;

  instr_addr_ctr #(.ADDR_W(ADDR_W), .ADDR_LIMIT(ADDR_LIMIT)) u_ctr (
    .clk(clk), .rst_n(rst_n), .load(load), .load_addr(data_in[ADDR_W-1:0]), .inc(inc),
    .addr(addr), .oor(oor), .ld_oor(ld_oor), .inc_oor(inc_oor)
  );

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    read_d = 1'b0;
    write_d = 1'b0;
    load = 1'b0;
    inc = 1'b0;
    data_out_d = data_out_q;
    data_write_d = data_write_q;
    case (state_q)
      IDLE: if (byte_sync && !frame_end) begin
        load = 1'b1;
        burst_d = data_in[CMD_BURST_BIT];
        state_d = data_in[CMD_WR_BIT] ? WR_DATA : RD_LOAD;
        read_d = !data_in[CMD_WR_BIT] && !ld_oor;
      end
      WR_DATA: begin
        // burst address advances in the strobe cycle, after the write has used it
        inc = write_q && burst_q;
        if (byte_sync) begin
          write_d = !oor;
          data_write_d = data_in;
          state_d = (burst_q && !frame_end) ? WR_DATA : IDLE;
        end else if (frame_end) state_d = IDLE;
      end
      RD_LOAD: begin
        data_out_d = oor ? RD_FILL : data_read;
        state_d = frame_end ? IDLE : RD_SHIFT;
      end
      RD_SHIFT: if (frame_end) state_d = IDLE;
        else if (byte_sync) begin
          inc = burst_q;
          read_d = burst_q && !inc_oor;
          state_d = burst_q ? RD_LOAD : IDLE;
        end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      burst_q <= 1'b0;
      read_q <= 1'b0;
      write_q <= 1'b0;
      busy_q <= 1'b0;
      data_out_q <= 8'h00;
      data_write_q <= 8'h00;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      read_q <= read_d;
      write_q <= write_d;
      busy_q <= busy_d;
      data_out_q <= data_out_d;
      data_write_q <= data_write_d;
    end

  assign read = read_q;
  assign write = write_q;
  assign busy = busy_q;
  assign data_out = data_out_q;
  assign data_write = data_write_q;

`ifdef INSTR_DCD_ERR_EN
  logic err_q, err_d, wr_seen_q, wr_seen_d, err_set;
  always_comb begin
    err_set = (state_q == IDLE && byte_sync && !frame_end && !data_in[CMD_WR_BIT] && ld_oor)
           || (state_q == WR_DATA && byte_sync && oor)
           || (state_q == WR_DATA && frame_end && !byte_sync && !wr_seen_q)
           || (state_q == RD_SHIFT && byte_sync && !frame_end && burst_q && inc_oor);
    wr_seen_d = (state_q == IDLE) ? 1'b0 : wr_seen_q || (state_q == WR_DATA && byte_sync);
    err_d = err_set || (err_q && !err_clr);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err_q <= 1'b0;
      wr_seen_q <= 1'b0;
    end else begin
      err_q <= err_d;
      wr_seen_q <= wr_seen_d;
    end
  assign err = err_q;
`endif
endmodule

// File: tb/tb_instr_dcd_burst.sv
// tb_instr_dcd_burst: directed checks of instr_dcd_burst with ADDR_LIMIT=8 and a register-file model
module tb_instr_dcd_burst;
  logic clk = 1'b0, rst_n = 1'b0, byte_sync = 1'b0, frame_end = 1'b0;
  logic [7:0] data_in = 8'h00, data_out, data_read, data_write;
  logic read, write, busy;
  logic [5:0] addr;
  logic [7:0] regs [64];
  logic [13:0] wq [$];
  int n_rd = 0, n_both = 0, n_chk = 0, n_err = 0, r0;
`ifdef INSTR_DCD_ERR_EN
  logic err, err_clr = 1'b0;
`endif

  always #5 clk = ~clk;
  assign data_read = regs[addr];

  instr_dcd_burst #(.ADDR_W(6), .ADDR_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .byte_sync(byte_sync), .frame_end(frame_end),
    .data_in(data_in), .data_out(data_out), .read(read), .write(write), .addr(addr),
    .data_read(data_read), .data_write(data_write),
`ifdef INSTR_DCD_ERR_EN
    .err(err), .err_clr(err_clr),
`endif
    .busy(busy)
  );

  always @(posedge clk) begin
    if (write) wq.push_back({addr, data_write});
    if (read) n_rd++;
    if (read && write) n_both++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic fe);
    @(negedge clk);
    byte_sync = 1'b1;
    data_in = b;
    frame_end = fe;
    @(negedge clk);
    byte_sync = 1'b0;
    frame_end = 1'b0;
  endtask

  task automatic end_frame;
    @(negedge clk);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  task automatic check_wr(input string tag, input logic [5:0] a, input logic [7:0] d);
    logic [13:0] w;
    w = '1;
    if (wq.size() > 0) w = wq.pop_front();
    check(tag, 32'(w), 32'({a, d}));
  endtask

`ifdef INSTR_DCD_ERR_EN
  task automatic check_err_and_clear(input string tag);
    check(tag, err, 1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check({tag, "_clr"}, err, 0);
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) regs[i] = 8'h00;
    regs[0] = 8'hF0;
    regs[1] = 8'hF1;
    regs[3] = 8'h5C;
    regs[10] = 8'h77;
    repeat (2) @(negedge clk);
    check("rst_read", read, 0);
    check("rst_write", write, 0);
    check("rst_addr", addr, 0);
    check("rst_dwr", data_write, 0);
    check("rst_dout", data_out, 0);
    check("rst_busy", busy, 0);
`ifdef INSTR_DCD_ERR_EN
    check("rst_err", err, 0);
`endif
    rst_n = 1'b1;

    send(8'h85, 1'b0);
    check("wr_busy", busy, 1);
    send(8'hA5, 1'b0);
    check("wr_stb", write, 1);
    check("wr_addr", addr, 5);
    check("wr_data", data_write, 8'hA5);
    check("wr_busy_end", busy, 0);
    @(negedge clk);
    check("wr_one_cycle", write, 0);
    check("wr_count", wq.size(), 1);
    wq.delete();

    r0 = n_rd;
    send(8'h03, 1'b0);
    check("rd_stb", read, 1);
    check("rd_addr", addr, 3);
    @(negedge clk);
    check("rd_data", data_out, 8'h5C);
    check("rd_stb_off", read, 0);
    send(8'h00, 1'b0);
    check("rd_idle", busy, 0);
    check("rd_count", n_rd - r0, 1);

    send(8'hC2, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    end_frame();
    check("bw_idle", busy, 0);
    check("bw_n", wq.size(), 3);
    check_wr("bw0", 6'd2, 8'h11);
    check_wr("bw1", 6'd3, 8'h22);
    check_wr("bw2", 6'd4, 8'h33);

    send(8'hC7, 1'b0);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    end_frame();
    check("wrap_n", wq.size(), 2);
    check_wr("wrap0", 6'd7, 8'hAA);
    check_wr("wrap1", 6'd0, 8'hBB);

    send(8'hC2, 1'b0);
    send(8'h55, 1'b1);
    check("wfe_stb", write, 1);
    check("wfe_addr", addr, 2);
    check("wfe_busy", busy, 0);
    @(negedge clk);
    check("wfe_off", write, 0);
    check("wfe_n", wq.size(), 1);
    wq.delete();

    r0 = n_rd;
    send(8'h0A, 1'b0);
    check("oor_rd_stb", read, 0);
    check("oor_rd_addr", addr, 10);
`ifdef INSTR_DCD_ERR_EN
    check("oor_rd_err", err, 1);
`endif
    @(negedge clk);
    check("oor_rd_fill", data_out, 8'h00);
    end_frame();
    check("oor_rd_n", n_rd - r0, 0);
    check("oor_rd_idle", busy, 0);
`ifdef INSTR_DCD_ERR_EN
    check_err_and_clear("oor_rd_err_hold");
`endif

    send(8'h8A, 1'b0);
    send(8'h12, 1'b0);
    check("oor_wr_stb", write, 0);
    @(negedge clk);
    check("oor_wr_n", wq.size(), 0);
    check("oor_wr_idle", busy, 0);
`ifdef INSTR_DCD_ERR_EN
    check_err_and_clear("oor_wr_err");
    send(8'h81, 1'b0);
    end_frame();
    check("nodata_idle", busy, 0);
    check_err_and_clear("nodata_err");
`endif

    r0 = n_rd;
    send(8'h40, 1'b0);
    check("br_stb0", read, 1);
    check("br_addr0", addr, 0);
    send(8'h00, 1'b0);
    check("br_stb1", read, 1);
    check("br_addr1", addr, 1);
    check("br_dout0", data_out, 8'hF0);
    end_frame();
    check("br_abort_n", n_rd - r0, 2);
    check("br_abort_idle", busy, 0);
    check("br_dout1", data_out, 8'hF1);

    r0 = n_rd;
    send(8'h40, 1'b0);
    send(8'h00, 1'b1);
    check("brfe_stb", read, 0);
    check("brfe_idle", busy, 0);
    @(negedge clk);
    check("brfe_n", n_rd - r0, 1);

    send(8'hC1, 1'b0);
    send(8'h99, 1'b0);
    check("rst_mid_stb", write, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_write", write, 0);
    check("rst_mid_read", read, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_addr", addr, 0);
    check("rst_mid_dwr", data_write, 0);
    check("rst_mid_dout", data_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("no_overlap", n_both, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
